vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator: divides the system clock into a pixel-enable tick and walks horizontal and vertical counters through the active, front-porch, sync and back-porch phases. It drives pixel coordinates, sync pulses, an active-video flag and line/frame start strobes to the game renderer and pixel mux. Any mode (640x480, 800x600, ...) is selected by parameters alone.

---
 rtl/vga_timing_gen.sv | 125 ++++++++++++
 tb/tb_vga_timing_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-tick divider, h/v phase FSMs, registered sync/active/strobe outputs.
// Optional frame counter enabled by `define VGA_TIMING_FRAME_CNT_EN (otherwise frame_cnt_o is tied to 0).
module vga_timing_gen #(
   parameter int   DW         = 10,
   parameter int   CLK_DIV    = 2,
   parameter int   H_ACTIVE   = 640,
   parameter int   H_FP       = 16,
   parameter int   H_SYNC     = 96,
   parameter int   H_BP       = 48,
   parameter int   V_ACTIVE   = 480,
   parameter int   V_FP       = 10,
   parameter int   V_SYNC     = 2,
   parameter int   V_BP       = 29,
   parameter logic H_SYNC_POL = 1'b0,
   parameter logic V_SYNC_POL = 1'b0
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          enable_i,
   output logic [DW-1:0] x_o,
   output logic [DW-1:0] y_o,
   output logic          h_sync_o,
   output logic          v_sync_o,
   output logic          active_o,
   output logic          tick_o,
   output logic          line_start_o,
   output logic          frame_start_o,
   output logic [15:0]   frame_cnt_o
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DW-1:0] H_LAST     = DW'(H_TOTAL - 1);
   localparam logic [DW-1:0] H_FP_START = DW'(H_ACTIVE);
   localparam logic [DW-1:0] H_SY_START = DW'(H_ACTIVE + H_FP);
   localparam logic [DW-1:0] H_BP_START = DW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [DW-1:0] V_LAST     = DW'(V_TOTAL - 1);
   localparam logic [DW-1:0] V_FP_START = DW'(V_ACTIVE);
   localparam logic [DW-1:0] V_SY_START = DW'(V_ACTIVE + V_FP);
   localparam logic [DW-1:0] V_BP_START = DW'(V_ACTIVE + V_FP + V_SYNC);

   typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNCST, H_BACK} h_state_t;
   typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNCST, V_BACK} v_state_t;

   logic [DIV_W-1:0] div;
   logic             tick;
   logic             x_wrap;
   logic             y_wrap;
   logic [DW-1:0]    x_nxt;
   logic [DW-1:0]    y_nxt;
   h_state_t         h_state;
   h_state_t         h_nxt;
   v_state_t         v_state;
   v_state_t         v_nxt;

   assign tick   = enable_i && (div == DIV_LAST);
   assign x_wrap = (x_o == H_LAST);
   assign y_wrap = (y_o == V_LAST);
   assign x_nxt  = x_wrap ? '0 : x_o + 1'b1;
   assign y_nxt  = x_wrap ? (y_wrap ? '0 : y_o + 1'b1) : y_o;

   // Later phase boundaries win so zero-width porches still sequence correctly.
   always_comb begin
      h_nxt = h_state;
      if (x_nxt == '0)             h_nxt = H_ACT;
      else if (x_nxt == H_BP_START) h_nxt = H_BACK;
      else if (x_nxt == H_SY_START) h_nxt = H_SYNCST;
      else if (x_nxt == H_FP_START) h_nxt = H_FRONT;

      v_nxt = v_state;
      if (x_wrap) begin
         if (y_nxt == '0)             v_nxt = V_ACT;
         else if (y_nxt == V_BP_START) v_nxt = V_BACK;
         else if (y_nxt == V_SY_START) v_nxt = V_SYNCST;
         else if (y_nxt == V_FP_START) v_nxt = V_FRONT;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         div           <= '0;
         x_o           <= H_LAST;
         y_o           <= V_LAST;
         h_state       <= H_BACK;
         v_state       <= V_BACK;
         h_sync_o      <= ~H_SYNC_POL;
         v_sync_o      <= ~V_SYNC_POL;
         active_o      <= 1'b0;
         tick_o        <= 1'b0;
         line_start_o  <= 1'b0;
         frame_start_o <= 1'b0;
      end else begin
         tick_o        <= tick;
         line_start_o  <= tick && x_wrap;
         frame_start_o <= tick && x_wrap && y_wrap;
         if (enable_i) div <= tick ? '0 : div + 1'b1;
         if (tick) begin
            x_o      <= x_nxt;
            y_o      <= y_nxt;
            h_state  <= h_nxt;
            v_state  <= v_nxt;
            h_sync_o <= (h_nxt == H_SYNCST) ? H_SYNC_POL : ~H_SYNC_POL;
            v_sync_o <= (v_nxt == V_SYNCST) ? V_SYNC_POL : ~V_SYNC_POL;
            active_o <= (h_nxt == H_ACT) && (v_nxt == V_ACT);
         end
      end
   end

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] frame_cnt;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)                       frame_cnt <= '0;
      else if (tick && x_wrap && y_wrap) frame_cnt <= frame_cnt + 16'd1;
   end

   assign frame_cnt_o = frame_cnt;
`else
   assign frame_cnt_o = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480, 800x600 at CLK_DIV=1 with positive syncs, and a tiny fast-frame mode.
module tb_vga_timing_gen;

   localparam int NI = 3;
   localparam int DWS  [NI] = '{10, 11, 4};
   localparam int CDV  [NI] = '{2, 1, 3};
   localparam int HA   [NI] = '{640, 800, 6};
   localparam int HF   [NI] = '{16, 40, 2};
   localparam int HS   [NI] = '{96, 128, 3};
   localparam int HB   [NI] = '{48, 88, 2};
   localparam int VA   [NI] = '{480, 600, 4};
   localparam int VF   [NI] = '{10, 1, 1};
   localparam int VS   [NI] = '{2, 4, 2};
   localparam int VB   [NI] = '{29, 23, 1};
   localparam bit HPOL [NI] = '{1'b0, 1'b1, 1'b0};
   localparam bit VPOL [NI] = '{1'b0, 1'b1, 1'b0};
`ifdef VGA_TIMING_FRAME_CNT_EN
   localparam int FC_EXP = 3;
`else
   localparam int FC_EXP = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic en  = 1'b1;

   logic [10:0] xa [NI];
   logic [10:0] ya [NI];
   logic        hsa [NI];
   logic        vsa [NI];
   logic        acta [NI];
   logic        ticka [NI];
   logic        lsa [NI];
   logic        fsa [NI];
   logic [15:0] fca [NI];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [47:0] pk(input logic [15:0] fc, input logic fs, input logic ls,
                                      input logic tk, input logic act, input logic vs,
                                      input logic hs, input logic [10:0] y, input logic [10:0] x);
      return {4'b0, fc, fs, ls, tk, act, vs, hs, y, x};
   endfunction

   genvar g;
   generate
      for (g = 0; g < NI; g++) begin : g_dut
         localparam int HT  = HA[g] + HF[g] + HS[g] + HB[g];
         localparam int VT  = VA[g] + VF[g] + VS[g] + VB[g];
         localparam int HS0 = HA[g] + HF[g];
         localparam int HS1 = HA[g] + HF[g] + HS[g];
         localparam int VS0 = VA[g] + VF[g];
         localparam int VS1 = VA[g] + VF[g] + VS[g];

         logic [DWS[g]-1:0] xl;
         logic [DWS[g]-1:0] yl;
         logic [47:0]       q [$];
         int                mdiv;
         int                mx;
         int                my;
         logic [15:0]       mfc;
         logic              mt;
         logic              ml;
         logic              mf;

         vga_timing_gen #(
            .DW(DWS[g]), .CLK_DIV(CDV[g]),
            .H_ACTIVE(HA[g]), .H_FP(HF[g]), .H_SYNC(HS[g]), .H_BP(HB[g]),
            .V_ACTIVE(VA[g]), .V_FP(VF[g]), .V_SYNC(VS[g]), .V_BP(VB[g]),
            .H_SYNC_POL(HPOL[g]), .V_SYNC_POL(VPOL[g])
         ) u_dut (
            .clk_i(clk), .rst_i(rst), .enable_i(en),
            .x_o(xl), .y_o(yl),
            .h_sync_o(hsa[g]), .v_sync_o(vsa[g]), .active_o(acta[g]),
            .tick_o(ticka[g]), .line_start_o(lsa[g]), .frame_start_o(fsa[g]),
            .frame_cnt_o(fca[g])
         );

         assign xa[g] = 11'(xl);
         assign ya[g] = 11'(yl);

         // Reference raster: position counters, outputs decoded from position ranges.
         initial begin
            mdiv = 0; mx = HT - 1; my = VT - 1; mfc = '0;
            mt = 1'b0; ml = 1'b0; mf = 1'b0;
            forever begin
               @(posedge clk);
               mt = 1'b0; ml = 1'b0; mf = 1'b0;
               if (!rst) begin
                  mdiv = 0; mx = HT - 1; my = VT - 1; mfc = '0;
               end else if (en) begin
                  if (mdiv == CDV[g] - 1) begin
                     mdiv = 0;
                     mt   = 1'b1;
                     if (mx == HT - 1) begin
                        mx = 0;
                        ml = 1'b1;
                        if (my == VT - 1) begin
                           my = 0;
                           mf = 1'b1;
`ifdef VGA_TIMING_FRAME_CNT_EN
                           mfc = mfc + 16'd1;
`endif
                        end else begin
                           my = my + 1;
                        end
                     end else begin
                        mx = mx + 1;
                     end
                  end else begin
                     mdiv = mdiv + 1;
                  end
               end
               q.push_back(pk(mfc, mf, ml, mt, (mx < HA[g]) && (my < VA[g]),
                              (my >= VS0 && my < VS1) ? VPOL[g] : ~VPOL[g],
                              (mx >= HS0 && mx < HS1) ? HPOL[g] : ~HPOL[g],
                              11'(my), 11'(mx)));
            end
         end

         initial begin
            forever begin
               @(negedge clk);
               if (q.size() != 0)
                  check_eq($sformatf("sb%0d", g),
                           pk(fca[g], fsa[g], lsa[g], ticka[g], acta[g], vsa[g], hsa[g], ya[g], xa[g]),
                           q.pop_front());
            end
         end
      end
   endgenerate

   initial begin
      int cnt, hmin, hmax, act_fall, stb, nfs, fs_last, fs_period, fc_at3;
      int vmin, vmax, xmax1, hs1_first;

      rst = 1'b0;
      en  = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_x", 48'(xa[0]), 48'd799);
      check_eq("rst_y", 48'(ya[0]), 48'd520);
      check_eq("rst_hs", 48'(hsa[0]), 48'd1);
      check_eq("rst_vs", 48'(vsa[0]), 48'd1);
      check_eq("rst_act", 48'(acta[0]), 48'd0);
      check_eq("rst_strobes", 48'({ticka[0], lsa[0], fsa[0]}), 48'd0);
      check_eq("rst_fc", 48'(fca[0]), 48'd0);

      #1 rst = 1'b1;
      @(negedge clk);
      check_eq("pre_tick_x", 48'(xa[0]), 48'd799);
      check_eq("pre_tick_tick", 48'(ticka[0]), 48'd0);
      @(negedge clk);
      check_eq("first_x", 48'(xa[0]), 48'd0);
      check_eq("first_y", 48'(ya[0]), 48'd0);
      check_eq("first_fs", 48'(fsa[0]), 48'd1);
      check_eq("first_ls", 48'(lsa[0]), 48'd1);
      check_eq("first_act", 48'(acta[0]), 48'd1);
      check_eq("first_tick", 48'(ticka[0]), 48'd1);
      @(negedge clk);
      check_eq("gap_tick", 48'(ticka[0]), 48'd0);
      @(negedge clk);
      check_eq("second_tick", 48'(ticka[0]), 48'd1);
      check_eq("second_x", 48'(xa[0]), 48'd1);

      // One full line: sync window, active fall, line period.
      cnt = 2; hmin = 9999; hmax = -1; act_fall = -1;
      do begin
         @(negedge clk);
         cnt++;
         if (hsa[0] == 1'b0) begin
            if (int'(xa[0]) < hmin) hmin = int'(xa[0]);
            if (int'(xa[0]) > hmax) hmax = int'(xa[0]);
         end
         if (!acta[0] && act_fall < 0) act_fall = int'(xa[0]);
      end while (!lsa[0] && cnt < 2000);
      check_eq("line_period", 48'(cnt), 48'd1600);
      check_eq("hs_lo_first", 48'(hmin), 48'd656);
      check_eq("hs_lo_last", 48'(hmax), 48'd751);
      check_eq("act_fall_x", 48'(act_fall), 48'd640);

      cnt = 0;
      while (xa[0] != 11'd300 && cnt < 2000) begin @(negedge clk); cnt++; end
      check_eq("wait_x300", 48'(xa[0]), 48'd300);
      #1 en = 1'b0;
      stb = 0;
      repeat (10) begin
         @(negedge clk);
         stb += int'(ticka[0]) + int'(lsa[0]) + int'(fsa[0]);
      end
      check_eq("hold_x", 48'(xa[0]), 48'd300);
      check_eq("hold_strobes", 48'(stb), 48'd0);
      #1 en = 1'b1;
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (!ticka[0] && cnt < 10);
      check_eq("resume_x", 48'(xa[0]), 48'd301);

      cnt = 0;
      while (xa[0] != 11'd700 && cnt < 2000) begin @(negedge clk); cnt++; end
      check_eq("wait_x700", 48'(xa[0]), 48'd700);
      check_eq("pre_rst_hs", 48'(hsa[0]), 48'd0);
      #2 rst = 1'b0;
      #1;
      check_eq("async_x", 48'(xa[0]), 48'd799);
      check_eq("async_y", 48'(ya[0]), 48'd520);
      check_eq("async_hs", 48'(hsa[0]), 48'd1);
      check_eq("async_act", 48'(acta[0]), 48'd0);
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;

      // Tiny mode frames and 800x600 line span, observed together.
      nfs = 0; fs_last = 0; fs_period = 0; fc_at3 = -1;
      vmin = 9999; vmax = -1; xmax1 = -1; hs1_first = -1;
      for (int c = 1; c <= 1300; c++) begin
         @(negedge clk);
         if (fsa[2]) begin
            nfs++;
            if (nfs == 3) begin
               fs_period = c - fs_last;
               fc_at3    = int'(fca[2]);
            end
            fs_last = c;
         end
         if (vsa[2] == 1'b0) begin
            if (int'(ya[2]) < vmin) vmin = int'(ya[2]);
            if (int'(ya[2]) > vmax) vmax = int'(ya[2]);
         end
         if (int'(xa[1]) > xmax1) xmax1 = int'(xa[1]);
         if (hsa[1] && hs1_first < 0) hs1_first = int'(xa[1]);
      end
      check_eq("tiny_frames", 48'(nfs >= 3), 48'd1);
      check_eq("tiny_frame_period", 48'(fs_period), 48'd312);
      check_eq("frame_cnt_at3", 48'(fc_at3), 48'(FC_EXP));
      check_eq("tiny_vs_lo_first", 48'(vmin), 48'd5);
      check_eq("tiny_vs_lo_last", 48'(vmax), 48'd6);
      check_eq("h_total_800x600", 48'(xmax1 + 1), 48'd1056);
      check_eq("hs_pos_first_800x600", 48'(hs1_first), 48'd840);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
